// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// The FSM state type and counter-width function live here so all files agree.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   // Width of the bit counter: indices 0..width-1, at least one bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_sub_fs_cell.sv
// Combinational one-bit full subtractor: d = a - b - bin, with borrow-out.
module fs_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial ripple-borrow subtractor: diff = a - b (mod 2^WIDTH), one bit per clock,
// LSB first, with valid/ready handshakes on the operand and result sides.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int unsigned     CntW    = cnt_width(WIDTH);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   logic cell_d;
   logic cell_bout;

   fs_cell u_fs_cell (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .bin  (borrow_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d      = a;
               b_d      = b;
               borrow_d = 1'b0;
               cnt_d    = '0;
               state_d  = StRun;
            end
         end
         StRun: begin
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            diff_d   = {cell_d, diff_q[WIDTH-1:1]};
            borrow_d = cell_bout;
            // Counter parks at its last value instead of wrapping.
            if (cnt_q == CntLast) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
      end
   end

   // Handshake outputs come straight from the state register.
   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign diff      = diff_q;
   assign borrow    = borrow_q;

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub at WIDTH 8, 4 and 16: directed cases plus random traffic,
// checked every cycle against a transaction-level model of the handshakes and result.
module tb_serial_sub;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid_s  [3];
   logic        out_ready_s [3];
   logic [15:0] a_s         [3];
   logic [15:0] b_s         [3];
   logic        in_ready_s  [3];
   logic        out_valid_s [3];
   logic        borrow_s    [3];
   logic [15:0] diff_s      [3];

   logic [7:0]  diff8;
   logic [3:0]  diff4;
   logic [15:0] diff16;

   assign diff_s[0] = {8'h00, diff8};
   assign diff_s[1] = {12'h000, diff4};
   assign diff_s[2] = diff16;

   serial_sub #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
      .a(a_s[0][7:0]), .b(b_s[0][7:0]), .out_valid(out_valid_s[0]),
      .out_ready(out_ready_s[0]), .diff(diff8), .borrow(borrow_s[0])
   );
   serial_sub #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
      .a(a_s[1][3:0]), .b(b_s[1][3:0]), .out_valid(out_valid_s[1]),
      .out_ready(out_ready_s[1]), .diff(diff4), .borrow(borrow_s[1])
   );
   serial_sub #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
      .a(a_s[2]), .b(b_s[2]), .out_valid(out_valid_s[2]),
      .out_ready(out_ready_s[2]), .diff(diff16), .borrow(borrow_s[2])
   );

   int checks = 0;
   int errors = 0;

   function automatic int w_of(input int k);
      case (k)
         0:       return 8;
         1:       return 4;
         default: return 16;
      endcase
   endfunction

   function automatic logic [15:0] mask(input int k);
      return 16'((32'd1 << w_of(k)) - 32'd1);
   endfunction

   task automatic chk(input string name, input int k, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (width %0d) at %0t: got %h, expected %h", name, w_of(k), $time,
                  act, exp);
      end
   endtask

   // Transaction model: busy from accept until the result handshake; result ready
   // WIDTH edges after the accept edge; value is plain modular subtraction.
   bit          busy   [3];
   longint      acc    [3];
   logic [15:0] exp_d  [3];
   logic        exp_b  [3];
   int          results[3];
   longint      ecount = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) busy[k] <= 1'b0;
      end else begin
         ecount <= ecount + 1;
         for (int k = 0; k < 3; k++) begin
            if (busy[k]) begin
               if ((ecount - acc[k]) >= longint'(w_of(k)) && out_ready_s[k]) begin
                  busy[k]    <= 1'b0;
                  results[k] <= results[k] + 1;
               end
            end else if (in_valid_s[k]) begin
               busy[k]  <= 1'b1;
               acc[k]   <= ecount + 1;
               exp_d[k] <= (a_s[k] - b_s[k]) & mask(k);
               exp_b[k] <= (a_s[k] & mask(k)) < (b_s[k] & mask(k));
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         logic exp_ov;
         exp_ov = busy[k] && ((ecount - acc[k]) >= longint'(w_of(k)));
         chk("in_ready", k, 16'(in_ready_s[k]), 16'(!busy[k]));
         chk("out_valid", k, 16'(out_valid_s[k]), 16'(exp_ov));
         if (exp_ov && out_valid_s[k]) begin
            chk("diff", k, diff_s[k], exp_d[k]);
            chk("borrow", k, 16'(borrow_s[k]), 16'(exp_b[k]));
         end
      end
   end

   // One full transaction; junk scribbles on inputs that must be ignored.
   task automatic xfer(input int k, input logic [15:0] av, input logic [15:0] bv,
                       input int stall, input bit junk, output logic [15:0] d,
                       output logic bo, output int lat);
      int guard;
      d   = 'x;
      bo  = 1'bx;
      lat = -1;
      @(negedge clk);
      a_s[k]         = av;
      b_s[k]         = bv;
      in_valid_s[k]  = 1'b1;
      out_ready_s[k] = 1'b0;
      guard = 0;
      while (!in_ready_s[k] && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready_s[k]) begin
         chk("accept_timeout", k, 16'(in_ready_s[k]), 16'd1);
         in_valid_s[k] = 1'b0;
         return;
      end
      @(negedge clk);
      lat = 0;
      in_valid_s[k] = junk ? 1'($urandom) : 1'b0;
      if (junk) begin
         a_s[k] = 16'($urandom);
         b_s[k] = 16'($urandom);
      end
      while (!out_valid_s[k] && lat < 60) begin
         @(negedge clk);
         lat++;
         if (junk) begin
            in_valid_s[k] = 1'($urandom);
            a_s[k]        = 16'($urandom);
            b_s[k]        = 16'($urandom);
         end
      end
      if (!out_valid_s[k]) begin
         chk("result_timeout", k, 16'(out_valid_s[k]), 16'd1);
         in_valid_s[k] = 1'b0;
         return;
      end
      repeat (stall) begin
         @(negedge clk);
         if (junk) begin
            in_valid_s[k] = 1'($urandom);
            a_s[k]        = 16'($urandom);
            b_s[k]        = 16'($urandom);
         end
      end
      in_valid_s[k]  = 1'b0;
      d              = diff_s[k];
      bo             = borrow_s[k];
      out_ready_s[k] = 1'b1;
      @(negedge clk);
      out_ready_s[k] = 1'b0;
   endtask

   task automatic rand_run(input int k, input int n);
      logic [15:0] av, bv, d;
      logic        bo;
      int          lat;
      for (int i = 0; i < n; i++) begin
         av = 16'($urandom) & mask(k);
         bv = 16'($urandom) & mask(k);
         xfer(k, av, bv, $urandom_range(0, 3), 1'b1, d, bo, lat);
         chk("rand_diff", k, d, (av - bv) & mask(k));
         chk("rand_borrow", k, 16'(bo), 16'(av < bv));
         chk("rand_latency", k, 16'(lat), 16'(w_of(k)));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d;
      logic        bo;
      int          lat;
      logic [15:0] rd [2];
      logic        rb [2];
      longint      re [2];
      int          got;

      for (int k = 0; k < 3; k++) begin
         in_valid_s[k]  = 1'b0;
         out_ready_s[k] = 1'b0;
         a_s[k]         = '0;
         b_s[k]         = '0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("reset_diff", k, diff_s[k], 16'h0000);
         chk("reset_borrow", k, 16'(borrow_s[k]), 16'd0);
         chk("reset_in_ready", k, 16'(in_ready_s[k]), 16'd1);
      end
      rst_n = 1'b1;

      xfer(0, 16'h5A, 16'h23, 0, 1'b0, d, bo, lat);
      chk("5A-23 diff", 0, d, 16'h0037);
      chk("5A-23 borrow", 0, 16'(bo), 16'd0);
      chk("5A-23 latency", 0, 16'(lat), 16'd8);
      xfer(0, 16'h00, 16'h01, 0, 1'b0, d, bo, lat);
      chk("00-01 diff", 0, d, 16'h00FF);
      chk("00-01 borrow", 0, 16'(bo), 16'd1);
      xfer(0, 16'h80, 16'h80, 0, 1'b0, d, bo, lat);
      chk("80-80 diff", 0, d, 16'h0000);
      chk("80-80 borrow", 0, 16'(bo), 16'd0);
      xfer(0, 16'hC3, 16'h3C, 20, 1'b1, d, bo, lat);
      chk("stall diff", 0, d, 16'h0087);
      chk("stall borrow", 0, 16'(bo), 16'd0);

      // Reset while the counter sits at 3.
      @(negedge clk);
      a_s[0] = 16'h5A;
      b_s[0] = 16'h23;
      in_valid_s[0] = 1'b1;
      @(negedge clk);
      in_valid_s[0] = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrun out_valid", 0, 16'(out_valid_s[0]), 16'd0);
      chk("midrun in_ready", 0, 16'(in_ready_s[0]), 16'd1);
      chk("midrun diff", 0, diff_s[0], 16'h0000);
      chk("midrun borrow", 0, 16'(borrow_s[0]), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      xfer(0, 16'h10, 16'h01, 0, 1'b0, d, bo, lat);
      chk("10-01 diff", 0, d, 16'h000F);
      chk("10-01 borrow", 0, 16'(bo), 16'd0);

      // Back-to-back with both valids held high.
      @(negedge clk);
      a_s[0] = 16'hFF;
      b_s[0] = 16'h01;
      in_valid_s[0]  = 1'b1;
      out_ready_s[0] = 1'b1;
      @(negedge clk);
      a_s[0] = 16'h01;
      b_s[0] = 16'hFF;
      got = 0;
      for (int i = 0; i < 60 && got < 2; i++) begin
         @(negedge clk);
         if (out_valid_s[0]) begin
            rd[got] = diff_s[0];
            rb[got] = borrow_s[0];
            re[got] = ecount;
            got++;
            if (got == 2) in_valid_s[0] = 1'b0;
         end
      end
      in_valid_s[0] = 1'b0;
      @(negedge clk);
      out_ready_s[0] = 1'b0;
      chk("b2b count", 0, 16'(got), 16'd2);
      if (got == 2) begin
         chk("b2b diff0", 0, rd[0], 16'h00FE);
         chk("b2b borrow0", 0, 16'(rb[0]), 16'd0);
         chk("b2b diff1", 0, rd[1], 16'h0002);
         chk("b2b borrow1", 0, 16'(rb[1]), 16'd1);
         chk("b2b spacing", 0, 16'(re[1] - re[0]), 16'd10);
      end

      results[1] = 0;
      results[2] = 0;
      fork
         rand_run(1, 1000);
         rand_run(2, 1000);
      join
      repeat (2) @(negedge clk);
      chk("rand results", 1, 16'(results[1]), 16'd1000);
      chk("rand results", 2, 16'(results[2]), 16'd1000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
